c3sram_row_scheduler: RTL

Schedules row operations into the C3SRAM write/read controller for two requesters: a bulk weight-load stream and a host single-row read port. It breaks a load command (base row, row count) into per-row writes with auto-incrementing, wrapping address. It arbitrates between load writes and host reads round-robin and drives the controller's one-cycle write/read strobes. It sits between the accelerator's configuration/host logic and the row write/read controller.

---
 rtl/row_sched_pkg.sv | 27 ++
 rtl/row_sched_rr_arb.sv | 50 +++++
 rtl/c3sram_row_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/row_sched_pkg.sv
// Shared types and helpers for the C3SRAM row scheduler.
// Perf counters are built only when ROW_SCHED_PERF_EN is defined.
package row_sched_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   typedef enum logic {
      GNT_WRITE = 1'b0,
      GNT_READ  = 1'b1
   } gnt_t;

   localparam int PERF_CNT_W = 16;

   // Saturating increment for the performance counters.
   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                     input logic en);
      if (en && (v != {PERF_CNT_W{1'b1}})) begin
         return v + PERF_CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/row_sched_rr_arb.sv
// Two-requester round-robin arbiter (write vs read) with a last-grant register.
// On a conflict the requester that was not granted last time wins.
module row_sched_rr_arb
   import row_sched_pkg::*;
(
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic upd_en,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr,
   output logic gnt_rd
);

   gnt_t last_gnt_r;

   // Grant selection, gated by the enable.
   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      if (en) begin
         if (req_wr && req_rd) begin
            if (last_gnt_r == GNT_WRITE) begin
               gnt_rd = 1'b1;
            end else begin
               gnt_wr = 1'b1;
            end
         end else begin
            gnt_wr = req_wr;
            gnt_rd = req_rd;
         end
      end else begin
         gnt_wr = 1'b0;
         gnt_rd = 1'b0;
      end
   end

   // Last-grant register; reset to WRITE so a read wins the first conflict.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         last_gnt_r <= GNT_WRITE;
      end else if (upd_en && gnt_wr) begin
         last_gnt_r <= GNT_WRITE;
      end else if (upd_en && gnt_rd) begin
         last_gnt_r <= GNT_READ;
      end
   end

endmodule

// File: rtl/c3sram_row_scheduler.sv
// Splits bulk load commands into per-row writes and arbitrates them against host reads
// toward the C3SRAM row controller. Optional perf counters: ROW_SCHED_PERF_EN.
module c3sram_row_scheduler
   import row_sched_pkg::*;
#(
   parameter int numRows = 8,
   parameter int numCols = 8,
   localparam int AW = (numRows > 1) ? $clog2(numRows) : 1,
   localparam int CW = $clog2(numRows + 1)
)(
   input  logic               clk,
   input  logic               nrst,
   input  logic               load_start_i,
   input  logic [AW-1:0]      load_base_i,
   input  logic [CW-1:0]      load_count_i,
   output logic               load_busy_o,
   output logic               load_done_o,
   input  logic               ld_valid_i,
   input  logic [numCols-1:0] ld_data_i,
   output logic               ld_ready_o,
   input  logic               rd_req_i,
   input  logic [AW-1:0]      rd_addr_i,
   output logic               rd_gnt_o,
   output logic               rd_done_o,
   output logic               ctl_write_o,
   output logic               ctl_read_o,
   output logic [AW-1:0]      ctl_addr_o,
   output logic [numCols-1:0] ctl_wr_data_o,
   input  logic               ctl_ready_i,
   input  logic               ctl_done_i
`ifdef ROW_SCHED_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_wr_cnt_o,
   output logic [PERF_CNT_W-1:0] perf_rd_cnt_o,
   output logic [PERF_CNT_W-1:0] perf_rd_stall_o
`endif
);

   state_t        state_r;
   state_t        state_nxt_s;
   gnt_t          op_r;
   logic          busy_r;
   logic          done_r;
   logic [AW-1:0] addr_r;
   logic [CW-1:0] cnt_r;
   logic          arb_en_s;
   logic          gnt_wr_s;
   logic          gnt_rd_s;
   logic          wr_fin_s;
   logic          rd_fin_s;

   assign arb_en_s = (state_r == S_IDLE) && ctl_ready_i;
   assign wr_fin_s = (state_r == S_WAIT) && (op_r == GNT_WRITE) && ctl_done_i;
   assign rd_fin_s = (state_r == S_WAIT) && (op_r == GNT_READ) && ctl_done_i;

   row_sched_rr_arb u_arb (
      .clk    (clk),
      .nrst   (nrst),
      .en     (arb_en_s),
      .upd_en (arb_en_s),
      .req_wr (busy_r && ld_valid_i),
      .req_rd (rd_req_i),
      .gnt_wr (gnt_wr_s),
      .gnt_rd (gnt_rd_s)
   );

   assign load_busy_o = busy_r;
   assign load_done_o = done_r;
   assign rd_done_o   = rd_fin_s;

   // Strobes and address/data are combinational with the grant so the op issues this cycle.
   always_comb begin
      ctl_write_o   = 1'b0;
      ctl_read_o    = 1'b0;
      ld_ready_o    = 1'b0;
      rd_gnt_o      = 1'b0;
      ctl_addr_o    = {AW{1'b0}};
      ctl_wr_data_o = {numCols{1'b0}};
      case ({gnt_wr_s, gnt_rd_s})
         2'b10: begin
            ctl_write_o   = 1'b1;
            ld_ready_o    = 1'b1;
            ctl_addr_o    = addr_r;
            ctl_wr_data_o = ld_data_i;
         end
         2'b01: begin
            ctl_read_o = 1'b1;
            rd_gnt_o   = 1'b1;
            ctl_addr_o = rd_addr_i;
         end
         default: begin
            ctl_write_o = 1'b0;
            ctl_read_o  = 1'b0;
         end
      endcase
   end

   // Next-state logic: one op in flight until the controller reports done.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (gnt_wr_s || gnt_rd_s) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (ctl_done_i) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register and the kind of op currently in flight.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r <= S_IDLE;
         op_r    <= GNT_WRITE;
      end else begin
         state_r <= state_nxt_s;
         if (gnt_rd_s) begin
            op_r <= GNT_READ;
         end else if (gnt_wr_s) begin
            op_r <= GNT_WRITE;
         end
      end
   end

   // Load command tracking: next row address (wrapping), rows remaining, busy and done.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         addr_r <= {AW{1'b0}};
         cnt_r  <= {CW{1'b0}};
      end else begin
         done_r <= 1'b0;
         if (wr_fin_s) begin
            cnt_r  <= cnt_r - CW'(1);
            addr_r <= (addr_r == AW'(numRows - 1)) ? {AW{1'b0}} : addr_r + AW'(1);
            if (cnt_r == CW'(1)) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end else if (load_start_i && !busy_r) begin
            if (load_count_i == {CW{1'b0}}) begin
               done_r <= 1'b1;
            end else begin
               busy_r <= 1'b1;
               addr_r <= load_base_i;
               cnt_r  <= load_count_i;
            end
         end
      end
   end

`ifdef ROW_SCHED_PERF_EN
   logic [PERF_CNT_W-1:0] perf_wr_r;
   logic [PERF_CNT_W-1:0] perf_rd_r;
   logic [PERF_CNT_W-1:0] perf_st_r;

   // Saturating completion and read-stall counters.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         perf_wr_r <= {PERF_CNT_W{1'b0}};
         perf_rd_r <= {PERF_CNT_W{1'b0}};
         perf_st_r <= {PERF_CNT_W{1'b0}};
      end else begin
         perf_wr_r <= sat_inc(perf_wr_r, wr_fin_s);
         perf_rd_r <= sat_inc(perf_rd_r, rd_fin_s);
         perf_st_r <= sat_inc(perf_st_r, rd_req_i && !gnt_rd_s);
      end
   end

   assign perf_wr_cnt_o   = perf_wr_r;
   assign perf_rd_cnt_o   = perf_rd_r;
   assign perf_rd_stall_o = perf_st_r;
`endif

endmodule
